// File: rtl/pipe_stage_fifo_pkg.sv
// pipe_stage_fifo_pkg
//   Shared types and helpers for the elastic inter-stage buffer.
//   - op_e         : per-cycle queue operation decoded from push/pop
//   - DROP_W/MAX   : width and ceiling of the flush drop counter
//   - drop_sat_add : saturating accumulate for the drop counter
package pipe_stage_fifo_pkg;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Encoding is {push, pop} so the decode is a straight cast.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] acc,
                                                     input logic [DROP_W-1:0] n);
    logic [DROP_W:0] s;
    s = {1'b0, acc} + {1'b0, n};
    return s[DROP_W] ? DROP_MAX : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
//   Elastic WIDTH x DEPTH queue placed between two processor stages.
//   Valid/ready on both sides; flush squashes all entries (and any push in
//   the same cycle) and accumulates the number of squashed entries.
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   flush           synchronous squash
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data head or NOP_VALUE
//   count           current occupancy
//   drop_count      entries discarded by flush, saturating at 255
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   drop_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH-1);

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + PTR_W'(1);
  endfunction

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DROP_W-1:0] drop_q,   drop_d;
  logic              push, pop;
  op_e               op;

  // Handshake outputs come from registered state only; a full buffer does
  // not accept even if the head leaves in the same cycle.
  assign in_ready   = (count_q < DEPTH_C);
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : NOP_VALUE;
  assign count      = count_q;
  assign drop_count = drop_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  assign op   = op_e'({push, pop});

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = drop_sat_add(drop_q, DROP_W'(count_q));
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + CNT_W'(1);
        end
        OP_POP: begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          count_d  = count_q - CNT_W'(1);
        end
        OP_BOTH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: out_data is masked to NOP_VALUE while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: three instances (DEPTH 4/2/3) sharing clock
// and reset. Accepted payloads are queued when driven; each instance's
// monitor pops and compares on every downstream handshake.
module tb_pipe_stage_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- instance A: DEPTH=4, NOP=F000 ----
  logic a_flush = 0, a_iv = 0, a_ir, a_ov, a_or = 0;
  logic [15:0] a_di = '0, a_do;
  logic [2:0] a_cnt;
  logic [7:0] a_drop;
  pipe_stage_fifo #(.WIDTH(16), .DEPTH(4), .NOP_VALUE(16'hF000)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_di), .out_valid(a_ov), .out_ready(a_or), .out_data(a_do),
    .count(a_cnt), .drop_count(a_drop));

  // ---- instance B: DEPTH=2, NOP=0 ----
  logic b_flush = 0, b_iv = 0, b_ir, b_ov, b_or = 0;
  logic [15:0] b_di = '0, b_do;
  logic [1:0] b_cnt;
  logic [7:0] b_drop;
  pipe_stage_fifo #(.WIDTH(16), .DEPTH(2), .NOP_VALUE(16'h0000)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_di), .out_valid(b_ov), .out_ready(b_or), .out_data(b_do),
    .count(b_cnt), .drop_count(b_drop));

  // ---- instance C: DEPTH=3, NOP=0 ----
  logic c_flush = 0, c_iv = 0, c_ir, c_ov, c_or = 0;
  logic [15:0] c_di = '0, c_do;
  logic [1:0] c_cnt;
  logic [7:0] c_drop;
  pipe_stage_fifo #(.WIDTH(16), .DEPTH(3), .NOP_VALUE(16'h0000)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_di), .out_valid(c_ov), .out_ready(c_or), .out_data(c_do),
    .count(c_cnt), .drop_count(c_drop));

  logic [15:0] sb_a[$], sb_b[$], sb_c[$];

  // Monitors sample mid-cycle, where inputs and state are stable.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_ov && a_or && !a_flush) begin
        if (sb_a.size() == 0) begin errors++; checks++; $display("FAIL a_pop: got %0h expected none", a_do); end
        else chk("a_pop", 32'(a_do), 32'(sb_a.pop_front()));
      end
      if (b_ov && b_or && !b_flush) begin
        if (sb_b.size() == 0) begin errors++; checks++; $display("FAIL b_pop: got %0h expected none", b_do); end
        else chk("b_pop", 32'(b_do), 32'(sb_b.pop_front()));
      end
      if (c_ov && c_or && !c_flush) begin
        if (sb_c.size() == 0) begin errors++; checks++; $display("FAIL c_pop: got %0h expected none", c_do); end
        else chk("c_pop", 32'(c_do), 32'(sb_c.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        acc;     // bench expects this offer to be accepted
    logic        exp_ir;
    logic        exp_ov;
    int          exp_cnt;
    logic [15:0] exp_do;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // DEPTH=2 backpressure table; expectations are the state after the edge.
    tbl[0] = '{1'b1, 16'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1, 16'hA};
    tbl[1] = '{1'b1, 16'hB, 1'b0, 1'b1, 1'b0, 1'b1, 2, 16'hA};
    tbl[2] = '{1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b1, 2, 16'hA};
    tbl[3] = '{1'b1, 16'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1, 16'hB}; // full: pop only
    tbl[4] = '{1'b1, 16'hC, 1'b0, 1'b1, 1'b0, 1'b1, 2, 16'hB};
    tbl[5] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 16'hC};
    tbl[6] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'h0};
    tbl[7] = '{1'b1, 16'hD, 1'b1, 1'b1, 1'b1, 1'b1, 1, 16'hD}; // empty: push only
    tbl[8] = '{1'b1, 16'hE, 1'b1, 1'b1, 1'b1, 1'b1, 1, 16'hE}; // push+pop
    tbl[9] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'h0};

    // Reset values
    #1;
    chk("rst_a_ir", 32'(a_ir), 32'd1);
    chk("rst_a_ov", 32'(a_ov), 32'd0);
    chk("rst_a_do", 32'(a_do), 32'hF000);
    chk("rst_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst_a_drop", 32'(a_drop), 32'd0);
    chk("rst_b_ir", 32'(b_ir), 32'd1);
    chk("rst_c_ov", 32'(c_ov), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // A: three pushes with downstream stalled
    for (int i = 1; i <= 3; i++) begin
      a_iv = 1'b1; a_di = 16'(i * 16'h1111);
      sb_a.push_back(a_di);
      tick();
    end
    a_iv = 1'b0;
    chk("a3_cnt", 32'(a_cnt), 32'd3);
    chk("a3_ir", 32'(a_ir), 32'd1);
    chk("a3_do", 32'(a_do), 32'h1111);

    // A: flush with a simultaneous offer; 0x55 must be lost
    a_flush = 1'b1; a_iv = 1'b1; a_di = 16'h0055;
    tick();
    a_flush = 1'b0; a_iv = 1'b0;
    sb_a.delete();
    chk("fl_cnt", 32'(a_cnt), 32'd0);
    chk("fl_ov", 32'(a_ov), 32'd0);
    chk("fl_do", 32'(a_do), 32'hF000);
    chk("fl_drop", 32'(a_drop), 32'd3);
    a_iv = 1'b1; a_di = 16'h0077; sb_a.push_back(16'h0077);
    tick();
    a_iv = 1'b0; a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk("fl_after_cnt", 32'(a_cnt), 32'd0);

    // A: drop_count saturation, flushes 2..86 each dropping 3
    for (int f = 2; f <= 86; f++) begin
      for (int k = 0; k < 3; k++) begin
        a_iv = 1'b1; a_di = 16'(f * 4 + k);
        tick();
      end
      a_iv = 1'b0; a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      if (f == 84) chk("drop_252", 32'(a_drop), 32'd252);
      if (f == 85) chk("drop_255", 32'(a_drop), 32'd255);
    end
    chk("drop_sat", 32'(a_drop), 32'd255);

    // B: table-driven DEPTH=2 backpressure
    for (int i = 0; i < 10; i++) begin
      b_iv = tbl[i].iv; b_di = tbl[i].din; b_or = tbl[i].ordy;
      if (tbl[i].acc) sb_b.push_back(tbl[i].din);
      tick();
      chk($sformatf("b%0d_ir", i), 32'(b_ir), 32'(tbl[i].exp_ir));
      chk($sformatf("b%0d_ov", i), 32'(b_ov), 32'(tbl[i].exp_ov));
      chk($sformatf("b%0d_cnt", i), 32'(b_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("b%0d_do", i), 32'(b_do), 32'(tbl[i].exp_do));
    end
    b_iv = 1'b0; b_or = 1'b0;

    // C: continuous streaming through DEPTH=3, wrapping pointers
    for (int i = 0; i < 10; i++) begin
      c_iv = 1'b1; c_di = 16'(i); c_or = 1'b1;
      sb_c.push_back(16'(i));
      tick();
      chk($sformatf("c%0d_cnt", i), 32'(c_cnt), 32'd1);
      chk($sformatf("c%0d_do", i), 32'(c_do), 32'(i));
    end
    c_iv = 1'b0;
    tick();
    c_or = 1'b0;
    chk("c_end_cnt", 32'(c_cnt), 32'd0);

    // A: asynchronous reset between edges with two entries held
    for (int i = 0; i < 2; i++) begin
      a_iv = 1'b1; a_di = 16'(16'h0900 + i);
      tick();
    end
    a_iv = 1'b0;
    chk("ar_pre_cnt", 32'(a_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("ar_ov", 32'(a_ov), 32'd0);
    chk("ar_cnt", 32'(a_cnt), 32'd0);
    chk("ar_drop", 32'(a_drop), 32'd0);
    chk("ar_do", 32'(a_do), 32'hF000);
    #2 reset = 1'b0;
    a_iv = 1'b1; a_di = 16'hABCD; sb_a.push_back(16'hABCD);
    tick();
    a_iv = 1'b0;
    chk("ar_post_ov", 32'(a_ov), 32'd1);
    chk("ar_post_do", 32'(a_do), 32'hABCD);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk("ar_post_cnt", 32'(a_cnt), 32'd0);

    // Every accepted payload must have been emitted
    chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
    chk("sb_b_empty", 32'(sb_b.size()), 32'd0);
    chk("sb_c_empty", 32'(sb_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
